uart_transmitter_param: RTL and testbench

UART_TRANSMITTER_PARAM -- requirements
Module: uart_transmitter_param

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_transmitter_param.sv | 154 +++++++++++++++
 tb/tb_uart_transmitter_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and parity-mode constants for the UART
// transmitter. The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  // Transmitter state encoding; codes are fixed so they stay stable across builds
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  // Parity-mode encoding on i_Parity_Mode (2'b11 is also treated as none)
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // True when the latched mode asks for a parity bit
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit from the XOR-reduction of the payload: even sends it as-is, odd inverts
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts CLKS_PER_BIT clocks per serial bit and strobes bit_end
// on the last cycle of each bit. restart holds the count at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic restart,
  output logic bit_end
);

  // Counter is exactly $clog2(CLKS_PER_BIT) wide; it only ever reaches CLKS_PER_BIT-1
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_COUNT = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_reg;

  // Free-running bit counter that wraps at the end of each bit or is held by restart
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      count_reg <= '0;
    end else if (restart || (count_reg == LAST_COUNT)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + TW'(1);
    end
  end

  assign bit_end = (count_reg == LAST_COUNT) && !restart;

endmodule

// File: rtl/uart_transmitter_param.sv
// uart_transmitter_param: UART transmitter, LSB first, 1 or 2 stop bits.
// Optional even/odd parity is compiled in by defining UART_TX_PARITY_EN;
// without it i_Parity_Mode is accepted but ignored and frames go DATA->STOP.
module uart_transmitter_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  input  logic [1:0]           i_Parity_Mode,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  // Bit index covers data bits and, in STOP, the stop-bit count
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_e            state_reg, state_next;
  logic [IW-1:0]        index_reg, index_next;
  logic [DATA_BITS-1:0] data_reg;
  logic                 serial_reg, serial_next;
  logic                 done_reg;
  logic                 bit_end;
  logic                 accept;

`ifdef UART_TX_PARITY_EN
  logic [1:0] mode_reg;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^i_Parity_Mode;
`endif

  assign o_Tx_Ready  = (state_reg == IDLE);
  assign o_Tx_Active = (state_reg != IDLE);
  assign o_Tx_Serial = serial_reg;
  assign o_Tx_Done   = done_reg;
  assign accept      = i_Tx_DV && o_Tx_Ready;

  // Timer sits at zero in IDLE so the start bit gets a full bit period
  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .restart (state_reg == IDLE),
    .bit_end (bit_end)
  );

  // Next state / bit index, and the line level for the state being entered
  always_comb begin
    state_next  = state_reg;
    index_next  = index_reg;
    serial_next = 1'b1;

    case (state_reg)
      IDLE: begin
        index_next = '0;
        if (accept) state_next = START;
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          index_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (index_reg == LAST_DATA) begin
            index_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = parity_enabled(mode_reg) ? PARITY : STOP;
`else
            state_next = STOP;
`endif
          end else begin
            index_next = index_reg + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          index_next = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (index_reg == LAST_STOP) begin
            state_next = IDLE;
            index_next = '0;
          end else begin
            index_next = index_reg + IW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase

    // Line is registered, so it is driven from the state we are moving into
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = data_reg[index_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_next = parity_bit(mode_reg, ^data_reg);
`endif
      default: serial_next = 1'b1;
    endcase
  end

  // State, bit index, serial line and the end-of-frame pulse
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg  <= IDLE;
      index_reg  <= '0;
      serial_reg <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      index_reg  <= index_next;
      serial_reg <= serial_next;
      done_reg   <= (state_reg == STOP) && (state_next == IDLE);
    end
  end

  // Capture payload (and parity mode) on accept so later input changes cannot touch the frame
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      data_reg <= '0;
`ifdef UART_TX_PARITY_EN
      mode_reg <= PAR_NONE;
`endif
    end else if (accept) begin
      data_reg <= i_Tx_Data;
`ifdef UART_TX_PARITY_EN
      mode_reg <= i_Parity_Mode;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter_param.sv
// tb_uart_transmitter_param: directed bench with a frame scoreboard. Three DUTs:
// (4 clk/bit, 1 stop), (4 clk/bit, 2 stop), (5208 clk/bit, 1 stop).
// Parity expectations follow UART_TX_PARITY_EN.
module tb_uart_transmitter_param;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic       i_Clock;
  logic       i_Reset;
  logic [2:0] dv_vec;
  logic [7:0] i_Tx_Data;
  logic [1:0] i_Parity_Mode;

  logic rdy0, act0, ser0, done0;
  logic rdy1, act1, ser1, done1;
  logic rdy2, act2, ser2, done2;
  logic m_rdy, m_act, m_ser, m_done;

  int     sel;
  int     vectors;
  int     miscompares;
  frame_t exp_q[$];

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  uart_transmitter_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Tx_DV(dv_vec[0]), .i_Tx_Data(i_Tx_Data),
    .i_Parity_Mode(i_Parity_Mode), .o_Tx_Ready(rdy0), .o_Tx_Active(act0),
    .o_Tx_Serial(ser0), .o_Tx_Done(done0));

  uart_transmitter_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2)) u_dut1 (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Tx_DV(dv_vec[1]), .i_Tx_Data(i_Tx_Data),
    .i_Parity_Mode(i_Parity_Mode), .o_Tx_Ready(rdy1), .o_Tx_Active(act1),
    .o_Tx_Serial(ser1), .o_Tx_Done(done1));

  uart_transmitter_param #(.CLKS_PER_BIT(5208), .DATA_BITS(8), .STOP_BITS(1)) u_dut2 (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Tx_DV(dv_vec[2]), .i_Tx_Data(i_Tx_Data),
    .i_Parity_Mode(i_Parity_Mode), .o_Tx_Ready(rdy2), .o_Tx_Active(act2),
    .o_Tx_Serial(ser2), .o_Tx_Done(done2));

  // Route the selected DUT's outputs to the monitor signals
  always_comb begin
    m_rdy = rdy0; m_act = act0; m_ser = ser0; m_done = done0;
    case (sel)
      1: begin m_rdy = rdy1; m_act = act1; m_ser = ser1; m_done = done1; end
      2: begin m_rdy = rdy2; m_act = act2; m_ser = ser2; m_done = done2; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits
  function automatic frame_t build(input logic [7:0] d, input logic [1:0] m, input int stops);
    frame_t f;
    int n;
    f.bits = '0;
    n = 0;
    f.bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin f.bits[n] = d[i]; n++; end
`ifdef UART_TX_PARITY_EN
    if (m == 2'b01) begin f.bits[n] = ^d; n++; end
    else if (m == 2'b10) begin f.bits[n] = ~(^d); n++; end
`else
    if (m == 2'b11) n = n + 0;
`endif
    for (int s = 0; s < stops; s++) begin f.bits[n] = 1'b1; n++; end
    f.len = n;
    return f;
  endfunction

  // Present one request on the selected DUT; it is accepted at the following posedge
  task automatic send(input logic [7:0] d, input logic [1:0] m, input int stops, input bit push);
    int w;
    w = 0;
    @(negedge i_Clock);
    while (m_rdy !== 1'b1 && w < 200) begin @(negedge i_Clock); w++; end
    chk("ready_before_send", {31'd0, m_rdy}, 32'd1);
    i_Tx_Data = d;
    i_Parity_Mode = m;
    dv_vec[sel] = 1'b1;
    @(posedge i_Clock);
    #1;
    dv_vec[sel] = 1'b0;
    if (push) exp_q.push_back(build(d, m, stops));
  endtask

  // Pop the next expected frame and check it cycle by cycle; optional mid-frame
  // junk request at sample glitch_at, optional chained request in the done cycle
  task automatic check_frame(input string tag, input int clks, input int glitch_at,
                             input bit chain, input logic [7:0] cd, input logic [1:0] cm,
                             input int cstops);
    frame_t f;
    int waited;
    int act_cnt;
    int done_early;
    int bit_err;
    waited = 0; act_cnt = 0; done_early = 0; bit_err = 0;
    chk({tag, "_queue_nonempty"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() == 0) return;
    f = exp_q.pop_front();
    @(negedge i_Clock);
    while (m_ser !== 1'b0 && waited < 20) begin @(negedge i_Clock); waited++; end
    chk({tag, "_start_latency"}, waited, 32'd0);
    for (int k = 0; k < f.len * clks; k++) begin
      if (k > 0) @(negedge i_Clock);
      if (k == glitch_at) begin
        i_Tx_Data = 8'hFF;
        i_Parity_Mode = ~i_Parity_Mode;
        dv_vec[sel] = 1'b1;
      end else if (k == glitch_at + 1) begin
        dv_vec[sel] = 1'b0;
      end
      if (m_ser !== f.bits[k / clks]) begin
        bit_err++;
        chk($sformatf("%s_bit%0d_cyc%0d", tag, k / clks, k), {31'd0, m_ser}, {31'd0, f.bits[k / clks]});
      end
      if (m_done !== 1'b0) done_early++;
      if (m_act === 1'b1) act_cnt++;
    end
    chk({tag, "_line_errors"}, bit_err, 32'd0);
    chk({tag, "_done_early"}, done_early, 32'd0);
    chk({tag, "_active_cycles"}, act_cnt, f.len * clks);
    @(negedge i_Clock);
    chk({tag, "_done_at_end"}, {31'd0, m_done}, 32'd1);
    chk({tag, "_active_low_at_end"}, {31'd0, m_act}, 32'd0);
    if (chain) begin
      i_Tx_Data = cd;
      i_Parity_Mode = cm;
      dv_vec[sel] = 1'b1;
      @(posedge i_Clock);
      #1;
      dv_vec[sel] = 1'b0;
      exp_q.push_back(build(cd, cm, cstops));
    end else begin
      @(negedge i_Clock);
      chk({tag, "_done_one_cycle"}, {31'd0, m_done}, 32'd0);
    end
  endtask

  initial begin
    int done_seen;
    logic [7:0] rd;
    vectors = 0;
    miscompares = 0;
    sel = 0;
    dv_vec = 3'b000;
    i_Tx_Data = 8'h00;
    i_Parity_Mode = 2'b00;
    i_Reset = 1'b1;

    // Reset state
    repeat (3) @(negedge i_Clock);
    chk("reset_serial", {31'd0, ser0}, 32'd1);
    chk("reset_active", {31'd0, act0}, 32'd0);
    chk("reset_done", {31'd0, done0}, 32'd0);
    chk("reset_ready", {31'd0, rdy0}, 32'd1);
    i_Reset = 1'b0;
    @(negedge i_Clock);
    $display("step: reset released");

    // Basic frames, each parity mode
    send(8'hA5, 2'b00, 1, 1'b1); check_frame("a5_none", 4, -1, 1'b0, 8'h00, 2'b00, 1);
    $display("frame a5 mode 00 checked");
    send(8'hA5, 2'b01, 1, 1'b1); check_frame("a5_even", 4, -1, 1'b0, 8'h00, 2'b00, 1);
    $display("frame a5 mode 01 checked");
    send(8'hA5, 2'b10, 1, 1'b1); check_frame("a5_odd", 4, -1, 1'b0, 8'h00, 2'b00, 1);
    $display("frame a5 mode 10 checked");
    send(8'hA5, 2'b11, 1, 1'b1); check_frame("a5_mode11", 4, -1, 1'b0, 8'h00, 2'b00, 1);
    $display("frame a5 mode 11 checked");

    // Junk request mid-frame, then a back-to-back request in the done cycle
    send(8'h96, 2'b01, 1, 1'b1); check_frame("96_glitch", 4, 10, 1'b1, 8'h3C, 2'b10, 1);
    $display("frame 96 with mid-frame request checked");
    check_frame("3c_chain", 4, -1, 1'b0, 8'h00, 2'b00, 1);
    $display("frame 3c back-to-back checked");

    // A few random payloads
    for (int r = 0; r < 3; r++) begin
      rd = 8'($urandom_range(0, 255));
      send(rd, 2'($urandom_range(0, 3)), 1, 1'b1);
      check_frame($sformatf("rand%0d", r), 4, -1, 1'b0, 8'h00, 2'b00, 1);
      $display("random frame %0d data %02h checked", r, rd);
    end

    // Reset during data bit 3 aborts the frame
    send(8'hA5, 2'b00, 1, 1'b0);
    repeat (18) @(negedge i_Clock);
    chk("abort_bit3_level", {31'd0, ser0}, 32'd0);
    i_Reset = 1'b1;
    #1;
    chk("abort_serial_high", {31'd0, ser0}, 32'd1);
    chk("abort_active_low", {31'd0, act0}, 32'd0);
    chk("abort_done_low", {31'd0, done0}, 32'd0);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    @(posedge i_Clock);
    #1;
    chk("abort_ready_after_release", {31'd0, rdy0}, 32'd1);
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_Clock);
      if (done0 !== 1'b0 || ser0 !== 1'b1) done_seen++;
    end
    chk("abort_no_done_line_idle", done_seen, 32'd0);
    $display("reset abort checked");

    // Two stop bits
    sel = 1;
    send(8'h00, 2'b00, 2, 1'b1); check_frame("00_stop2", 4, -1, 1'b0, 8'h00, 2'b00, 2);
    $display("frame 00 two stop bits checked");
    send(8'hA5, 2'b10, 2, 1'b1); check_frame("a5_odd_stop2", 4, -1, 1'b0, 8'h00, 2'b00, 2);
    $display("frame a5 odd two stop bits checked");

    // Full-width bit timer
    sel = 2;
    send(8'h55, 2'b00, 1, 1'b1); check_frame("55_5208", 5208, -1, 1'b0, 8'h00, 2'b00, 1);
    $display("frame 55 at 5208 clocks per bit checked");

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
